// File: rtl/idma_burst_sched_pkg.sv
// Shared iDMA burst-scheduler types and beat geometry constants.
// Beats are 256 bits (32 bytes); AXI INCR bursts carry at most 16 beats.
package idma_burst_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    localparam int unsigned BEAT_BYTES  = 32;
    localparam int unsigned BEAT_SHIFT  = 5;
    localparam int unsigned AXI_MAX_LEN = 16;

endpackage

// File: rtl/idma_os_cnt.sv
// Up/down counter of bursts in flight; saturates at MAX_CNT and stays at zero on underflow.
// cnt_d is exported so the owner can act on the next count in the same cycle.
module idma_os_cnt #(
    parameter int unsigned MAX_CNT = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           inc,
    input  logic                           dec,
    output logic [$clog2(MAX_CNT+1)-1:0]   cnt_q,
    output logic [$clog2(MAX_CNT+1)-1:0]   cnt_d,
    output logic                           underflow
);
    localparam int unsigned CW = $clog2(MAX_CNT + 1);

    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        if (inc && !dec) begin
            if (cnt_q != CW'(MAX_CNT)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec && !inc) begin
            if (cnt_q == '0) begin
                underflow = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/idma_burst_sched.sv
// Splits one iDMA descriptor into 32-byte-beat INCR bursts of at most MAX_BURST beats,
// throttled by the number of bursts whose data has not yet completed.
module idma_burst_sched
    import idma_burst_sched_pkg::*;
#(
    parameter int unsigned MAX_BURST       = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic                                   desc_valid,
    output logic                                   desc_ready,
    input  logic [31:0]                            desc_addr,
    input  logic [15:0]                            desc_beats,
    input  logic                                   sched_pause,
    output logic                                   dma_trans_burst_avalid,
    output logic [31:0]                            dma_trans_burst_addr,
    output logic [3:0]                             dma_trans_burst_len,
    input  logic                                   dma_xaddr_burst_ok,
    input  logic                                   axi_burst_xdata_ok,
    output logic                                   sched_busy,
    output logic                                   sched_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   sched_outstanding,
    output logic                                   sched_err
);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    sched_state_e   state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [15:0]    rem_q, rem_d;
    logic           hold_q, hold_d;
    logic           err_q, err_d;
    logic [4:0]     blen;
    logic           burst_ok;
    logic           underflow;
    logic [CW-1:0]  cnt_q, cnt_d;

    assign blen = (rem_q >= 16'(MAX_BURST)) ? 5'(MAX_BURST) : rem_q[4:0];

    // A pending request (hold) stays up regardless of pause or the in-flight limit.
    assign dma_trans_burst_avalid = (state_q == ST_ISSUE) &&
                                    (hold_q || ((cnt_q != CW'(MAX_OUTSTANDING)) && !sched_pause));
    assign burst_ok               = dma_trans_burst_avalid && dma_xaddr_burst_ok;
    assign dma_trans_burst_addr   = addr_q;
    assign dma_trans_burst_len    = (state_q == ST_ISSUE) ? 4'(blen - 5'd1) : 4'd0;

    assign desc_ready        = (state_q == ST_IDLE);
    assign sched_busy        = (state_q != ST_IDLE);
    assign sched_done        = (state_q == ST_DONE);
    assign sched_outstanding = cnt_q;
    assign sched_err         = err_q;

    idma_os_cnt #(
        .MAX_CNT (MAX_OUTSTANDING)
    ) u_os_cnt (
        .clk       (aclk),
        .rst_n     (aresetn),
        .inc       (burst_ok),
        .dec       (axi_burst_xdata_ok),
        .cnt_q     (cnt_q),
        .cnt_d     (cnt_d),
        .underflow (underflow)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        hold_d  = hold_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (desc_valid) begin
                    addr_d  = desc_addr & ~32'(BEAT_BYTES - 1);
                    rem_d   = desc_beats;
                    err_d   = 1'b0;
                    state_d = (desc_beats == 16'd0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (burst_ok) begin
                    addr_d = addr_q + (32'(blen) << BEAT_SHIFT);
                    rem_d  = rem_q - 16'(blen);
                    hold_d = 1'b0;
                    if (rem_q == 16'(blen)) begin
                        state_d = ST_DRAIN;
                    end
                end else if (dma_trans_burst_avalid) begin
                    hold_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Late completions with nothing in flight are flagged even in IDLE.
        if (underflow) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            hold_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_idma_burst_sched.sv
// Randomized bench for idma_burst_sched against a queue-based transfer model.
module tb_idma_burst_sched;
    localparam int MB = 16;
    localparam int MO = 2;
    localparam int CW = $clog2(MO + 1);

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          desc_valid = 1'b0;
    logic          desc_ready;
    logic [31:0]   desc_addr = '0;
    logic [15:0]   desc_beats = '0;
    logic          sched_pause = 1'b0;
    logic          dma_trans_burst_avalid;
    logic [31:0]   dma_trans_burst_addr;
    logic [3:0]    dma_trans_burst_len;
    logic          dma_xaddr_burst_ok = 1'b0;
    logic          axi_burst_xdata_ok = 1'b0;
    logic          sched_busy;
    logic          sched_done;
    logic [CW-1:0] sched_outstanding;
    logic          sched_err;

    idma_burst_sched #(.MAX_BURST(MB), .MAX_OUTSTANDING(MO)) dut (
        .aclk                   (aclk),
        .aresetn                (aresetn),
        .desc_valid             (desc_valid),
        .desc_ready             (desc_ready),
        .desc_addr              (desc_addr),
        .desc_beats             (desc_beats),
        .sched_pause            (sched_pause),
        .dma_trans_burst_avalid (dma_trans_burst_avalid),
        .dma_trans_burst_addr   (dma_trans_burst_addr),
        .dma_trans_burst_len    (dma_trans_burst_len),
        .dma_xaddr_burst_ok     (dma_xaddr_burst_ok),
        .axi_burst_xdata_ok     (axi_burst_xdata_ok),
        .sched_busy             (sched_busy),
        .sched_done             (sched_done),
        .sched_outstanding      (sched_outstanding),
        .sched_err              (sched_err)
    );

    always #5 aclk = ~aclk;

    // Model: list of bursts still to be requested, plus transfer bookkeeping.
    logic [31:0] q_addr[$];
    logic [3:0]  q_len[$];
    int          m_os = 0;
    bit          m_active = 0, m_done = 0, m_hold = 0, m_err = 0;
    int          checks = 0, errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic build_bursts(input logic [31:0] a_in, input int beats);
        logic [31:0] a;
        int r, bl;
        a = {a_in[31:5], 5'd0};
        r = beats;
        while (r > 0) begin
            bl = (r > MB) ? MB : r;
            q_addr.push_back(a);
            q_len.push_back(4'(bl - 1));
            a = a + 32'(bl * 32);
            r = r - bl;
        end
    endtask

    // One clock: drive inputs, answer the request, check outputs, advance the model.
    // xok_mode: 0 never, 1 random while bursts are in flight, 2 forced.
    task automatic step(input bit dv, input logic [31:0] da, input logic [15:0] db,
                        input int ok_pct, input int xok_mode, input int xok_pct,
                        input bit pz, output bit accepted);
        bit exp_av, exp_rdy, iss, drain, xok, err_set;
        int nos;
        @(posedge aclk);
        #1;
        desc_valid  = dv;
        desc_addr   = da;
        desc_beats  = db;
        sched_pause = pz;
        axi_burst_xdata_ok = (xok_mode == 2) ||
                             (xok_mode == 1 && m_os > 0 && $urandom_range(99) < 32'(xok_pct));
        #1;
        dma_xaddr_burst_ok = dma_trans_burst_avalid && ($urandom_range(99) < 32'(ok_pct));
        @(negedge aclk);
        exp_av  = m_active && q_addr.size() > 0 && (m_hold || (m_os < MO && !pz));
        exp_rdy = !m_active && !m_done;
        check_val("avalid", 32'(dma_trans_burst_avalid), 32'(exp_av));
        check_val("desc_ready", 32'(desc_ready), 32'(exp_rdy));
        check_val("busy", 32'(sched_busy), 32'(m_active || m_done));
        check_val("done", 32'(sched_done), 32'(m_done));
        check_val("outstanding", 32'(sched_outstanding), 32'(m_os));
        check_val("err", 32'(sched_err), 32'(m_err));
        if (exp_av) begin
            check_val("burst_addr", dma_trans_burst_addr, q_addr[0]);
            check_val("burst_len", 32'(dma_trans_burst_len), 32'(q_len[0]));
        end
        xok      = axi_burst_xdata_ok;
        accepted = dv && exp_rdy;
        iss      = exp_av && dma_xaddr_burst_ok;
        drain    = m_active && q_addr.size() == 0;
        err_set  = 0;
        nos      = m_os;
        if (iss && !xok) nos = m_os + 1;
        else if (!iss && xok) begin
            if (m_os == 0) err_set = 1;
            else nos = m_os - 1;
        end
        if (iss) begin
            $display("burst addr=0x%08h len=%0d", q_addr[0], q_len[0]);
            void'(q_addr.pop_front());
            void'(q_len.pop_front());
            m_hold = 0;
        end else if (exp_av) begin
            m_hold = 1;
        end
        m_done = 0;
        if (drain && nos == 0) begin
            m_active = 0;
            m_done   = 1;
        end
        m_os = nos;
        if (accepted) begin
            $display("desc addr=0x%08h beats=%0d", da, db);
            m_err = 0;
            build_bursts(da, int'(db));
            if (db == 16'd0) m_done = 1;
            else m_active = 1;
        end
        if (err_set) m_err = 1;
    endtask

    task automatic run_desc(input logic [31:0] a, input int beats, input int ok_pct,
                            input int xok_pct, input int pause_pct, input int xok_hold);
        bit acc = 0;
        int n = 0;
        while (!acc && n < 50) begin
            step(1'b1, a, 16'(beats), ok_pct, 1, xok_pct, 1'b0, acc);
            n++;
        end
        check_val("desc_accept_timeout", 32'(acc), 32'd1);
        n = 0;
        while ((m_active || m_done) && n < 3000) begin
            step(1'b0, '0, '0, ok_pct, (n >= xok_hold) ? 1 : 0, xok_pct,
                 $urandom_range(99) < 32'(pause_pct), acc);
            n++;
        end
        check_val("transfer_timeout", 32'(n < 3000), 32'd1);
    endtask

    initial begin
        bit acc;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_val("rst_ready", 32'(desc_ready), 32'd1);
        check_val("rst_avalid", 32'(dma_trans_burst_avalid), 32'd0);
        check_val("rst_addr", dma_trans_burst_addr, 32'd0);
        check_val("rst_len", 32'(dma_trans_burst_len), 32'd0);
        check_val("rst_outstanding", 32'(sched_outstanding), 32'd0);
        aresetn = 1'b1;

        run_desc(32'h0000_1000, 40, 100, 50, 0, 0);
        run_desc(32'h0000_101F, 5, 100, 60, 0, 0);
        run_desc(32'h0000_5000, 0, 100, 60, 0, 0);
        // Completion with nothing in flight raises the sticky error.
        step(1'b0, '0, '0, 0, 2, 100, 1'b0, acc);
        step(1'b0, '0, '0, 0, 0, 0, 1'b0, acc);
        run_desc(32'h0000_2000, 3, 100, 60, 0, 0);
        run_desc(32'h0000_3000, 64, 100, 60, 0, 10);
        run_desc(32'h0000_4000, 50, 20, 50, 50, 0);
        run_desc(32'hFFFF_FFC0, 20, 70, 50, 20, 0);
        for (int i = 0; i < 25; i++) begin
            run_desc($urandom, int'($urandom_range(0, 70)), int'($urandom_range(20, 100)),
                     int'($urandom_range(20, 80)), int'($urandom_range(0, 40)), 0);
        end

        // Reset while bursts are in flight abandons the transfer without a done pulse.
        step(1'b1, 32'h0000_8000, 16'd64, 100, 0, 0, 1'b0, acc);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 100, 0, 0, 1'b0, acc);
        check_val("pre_rst_outstanding", 32'(sched_outstanding), 32'(MO));
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        dma_xaddr_burst_ok = 1'b0;
        axi_burst_xdata_ok = 1'b0;
        #1;
        check_val("midrst_ready", 32'(desc_ready), 32'd1);
        check_val("midrst_busy", 32'(sched_busy), 32'd0);
        check_val("midrst_done", 32'(sched_done), 32'd0);
        check_val("midrst_avalid", 32'(dma_trans_burst_avalid), 32'd0);
        check_val("midrst_outstanding", 32'(sched_outstanding), 32'd0);
        check_val("midrst_err", 32'(sched_err), 32'd0);
        q_addr.delete();
        q_len.delete();
        m_os = 0; m_active = 0; m_done = 0; m_hold = 0; m_err = 0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 0, 0, 0, 1'b0, acc);
        run_desc(32'h0000_9000, 33, 100, 60, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
